// File: rtl/frame_signature.sv
// Per-frame CRC-16, pixel and line counts over the final video stream.
// Latched at each frame strobe, with timing-mismatch flags and a serial readout.
module frame_signature #(
    parameter logic [15:0] POLY       = 16'h1021,
    parameter logic [15:0] SEED       = 16'hFFFF,
    parameter int unsigned EXP_PIXELS = 480000,
    parameter int unsigned EXP_LINES  = 600
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [5:0]  rrggbb,
    input  logic        de,
    input  logic        next_frame,
    input  logic        freeze,
    input  logic        err_clear,
    input  logic        sig_load,
    input  logic        sig_shift,
    output logic [15:0] signature,
    output logic [19:0] pixel_count,
    output logic [9:0]  line_count,
    output logic        signature_valid,
    output logic        frame_error,
    output logic        error_sticky,
    output logic        sig_dout
);

    typedef enum logic {SYNC, RUN} state_t;

    state_t      state_q, state_d;
    logic        acc_clr, acc_en;
    logic [15:0] crc_q, crc_nxt;
    logic [19:0] pix_q, pix_nxt;
    logic [9:0]  line_q, line_nxt;
    logic        de_q;
    logic        latch_en, err_now;
    logic [15:0] rd_q;

    // Six MSB-first shift steps folded into one clock.
    function automatic logic [15:0] crc_step(
        input logic [15:0] c,
        input logic [5:0]  d
    );
        logic [15:0] r;
        logic        fb;
        r = c;
        for (int i = 5; i >= 0; i--) begin
            fb = r[15] ^ d[i];
            r  = {r[14:0], 1'b0} ^ (fb ? POLY : 16'h0000);
        end
        return r;
    endfunction

    always_comb begin
        crc_nxt  = de ? crc_step(crc_q, rrggbb) : crc_q;
        pix_nxt  = (de && pix_q != 20'hFFFFF) ? pix_q + 20'd1 : pix_q;
        line_nxt = (de && !de_q && line_q != 10'h3FF)
                   ? line_q + 10'd1 : line_q;
        err_now  = (pix_nxt != 20'(EXP_PIXELS)) ||
                   (line_nxt != 10'(EXP_LINES));
    end

    always_comb begin
        state_d  = state_q;
        acc_clr  = 1'b0;
        acc_en   = 1'b0;
        latch_en = 1'b0;
        unique case (state_q)
            SYNC: begin
                if (next_frame) begin
                    acc_clr = 1'b1;
                    state_d = RUN;
                end
            end
            RUN: begin
                acc_en = 1'b1;
                if (next_frame) begin
                    acc_clr  = 1'b1;
                    latch_en = !freeze;
                end
            end
            default: state_d = SYNC;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= SYNC;
        end else begin
            state_q <= state_d;
        end
    end

    // de_q tracks the raw qualifier so a frame can open mid-line.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            crc_q  <= SEED;
            pix_q  <= '0;
            line_q <= '0;
            de_q   <= 1'b0;
        end else begin
            de_q <= de;
            if (acc_clr) begin
                crc_q  <= SEED;
                pix_q  <= '0;
                line_q <= '0;
            end else if (acc_en) begin
                crc_q  <= crc_nxt;
                pix_q  <= pix_nxt;
                line_q <= line_nxt;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            signature       <= SEED;
            pixel_count     <= '0;
            line_count      <= '0;
            signature_valid <= 1'b0;
            frame_error     <= 1'b0;
        end else if (latch_en) begin
            signature       <= crc_nxt;
            pixel_count     <= pix_nxt;
            line_count      <= line_nxt;
            signature_valid <= 1'b1;
            frame_error     <= err_now;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            error_sticky <= 1'b0;
        end else if (latch_en && err_now) begin
            error_sticky <= 1'b1;
        end else if (err_clear) begin
            error_sticky <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_q     <= '0;
            sig_dout <= 1'b0;
        end else begin
            sig_dout <= rd_q[15];
            if (sig_load) begin
                rd_q <= signature;
            end else if (sig_shift) begin
                rd_q <= {rd_q[14:0], 1'b0};
            end
        end
    end

endmodule

// File: tb/tb_frame_signature.sv
// Directed bench for frame_signature on a reduced 4x5 frame geometry.
// Expected values are hand constants plus a small bit-level CRC reference.
module tb_frame_signature;

    localparam int unsigned EXP_PIX = 20;
    localparam int unsigned EXP_LN  = 4;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [5:0]  rrggbb;
    logic        de;
    logic        next_frame;
    logic        freeze;
    logic        err_clear;
    logic        sig_load;
    logic        sig_shift;
    logic [15:0] signature;
    logic [19:0] pixel_count;
    logic [9:0]  line_count;
    logic        signature_valid;
    logic        frame_error;
    logic        error_sticky;
    logic        sig_dout;

    int n_checks = 0;
    int n_fail   = 0;

    frame_signature #(
        .POLY       (16'h1021),
        .SEED       (16'hFFFF),
        .EXP_PIXELS (EXP_PIX),
        .EXP_LINES  (EXP_LN)
    ) dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .rrggbb          (rrggbb),
        .de              (de),
        .next_frame      (next_frame),
        .freeze          (freeze),
        .err_clear       (err_clear),
        .sig_load        (sig_load),
        .sig_shift       (sig_shift),
        .signature       (signature),
        .pixel_count     (pixel_count),
        .line_count      (line_count),
        .signature_valid (signature_valid),
        .frame_error     (frame_error),
        .error_sticky    (error_sticky),
        .sig_dout        (sig_dout)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Bit-serial CRC-16/CCITT reference over n pixels of one colour.
    function automatic logic [15:0] ref_crc(input int n, input logic [5:0] c);
        logic [15:0] r;
        logic        fb;
        r = 16'hFFFF;
        for (int k = 0; k < n; k++) begin
            for (int b = 5; b >= 0; b--) begin
                fb = r[15] ^ c[b];
                r  = {r[14:0], 1'b0};
                if (fb) r = r ^ 16'h1021;
            end
        end
        return r;
    endfunction

    task automatic strobe();
        next_frame = 1'b1;
        tick();
        next_frame = 1'b0;
    endtask

    task automatic send_frame(input int lines, input int ppl,
                              input logic [5:0] col, input bit drop);
        for (int l = 0; l < lines; l++) begin
            for (int p = 0; p < ppl; p++) begin
                de     = !(drop && l == lines - 1 && p == ppl - 1);
                rrggbb = col;
                tick();
            end
            de = 1'b0;
            tick();
            tick();
        end
        strobe();
    endtask

    logic [15:0] exp_seq;
    logic [15:0] word;
    logic [15:0] crc_a, crc_b, crc_c;

    initial begin
        reset_n    = 1'b0;
        rrggbb     = '0;
        de         = 1'b0;
        next_frame = 1'b0;
        freeze     = 1'b0;
        err_clear  = 1'b0;
        sig_load   = 1'b0;
        sig_shift  = 1'b0;
        crc_a      = ref_crc(20, 6'h2A);
        crc_b      = ref_crc(20, 6'h15);
        crc_c      = ref_crc(6, 6'h33);
        repeat (3) tick();
        reset_n = 1'b1;
        tick();

        check("rst_sig", signature, 16'hFFFF);
        check("rst_pix", pixel_count, 0);
        check("rst_lines", line_count, 0);
        check("rst_valid", signature_valid, 0);
        check("rst_ferr", frame_error, 0);
        check("rst_sticky", error_sticky, 0);
        check("rst_dout", sig_dout, 0);

        // First strobe only arms; second closes an empty frame.
        strobe();
        check("sync_nolatch", signature_valid, 0);
        repeat (99) tick();
        strobe();
        check("empty_sig", signature, 16'hFFFF);
        check("empty_pix", pixel_count, 0);
        check("empty_lines", line_count, 0);
        check("empty_valid", signature_valid, 1);
        check("empty_ferr", frame_error, 1);
        check("empty_sticky", error_sticky, 1);

        de     = 1'b1;
        rrggbb = 6'b000000;
        tick();
        de = 1'b0;
        tick();
        strobe();
        check("one_sig", signature, 16'h387C);
        check("one_pix", pixel_count, 1);
        check("one_lines", line_count, 1);

        sig_load = 1'b1;
        tick();
        sig_load = 1'b0;
        exp_seq  = 16'b0011100001111100;
        for (int k = 0; k < 16; k++) begin
            sig_shift = 1'b1;
            tick();
            check($sformatf("dout%0d", k), sig_dout, exp_seq[15 - k]);
        end
        sig_shift = 1'b0;

        sig_load  = 1'b1;
        sig_shift = 1'b1;
        tick();
        sig_load = 1'b0;
        word     = '0;
        for (int k = 0; k < 16; k++) begin
            tick();
            word = {word[14:0], sig_dout};
        end
        sig_shift = 1'b0;
        check("load_wins", word, 16'h387C);

        send_frame(4, 5, 6'h2A, 1'b0);
        check("fullA_sig", signature, crc_a);
        check("fullA_pix", pixel_count, 20);
        check("fullA_lines", line_count, 4);
        check("fullA_ferr", frame_error, 0);
        check("fullA_sticky", error_sticky, 1);
        err_clear = 1'b1;
        tick();
        err_clear = 1'b0;
        check("clr_sticky", error_sticky, 0);
        send_frame(4, 5, 6'h2A, 1'b0);
        check("fullA2_sig", signature, crc_a);

        freeze = 1'b1;
        send_frame(4, 5, 6'h15, 1'b1);
        freeze = 1'b0;
        check("frz_sig", signature, crc_a);
        check("frz_pix", pixel_count, 20);
        check("frz_ferr", frame_error, 0);
        check("frz_sticky", error_sticky, 0);
        send_frame(4, 5, 6'h15, 1'b0);
        check("fullB_sig", signature, crc_b);

        send_frame(4, 5, 6'h15, 1'b1);
        check("drop_pix", pixel_count, 19);
        check("drop_lines", line_count, 4);
        check("drop_ferr", frame_error, 1);
        check("drop_sticky", error_sticky, 1);

        err_clear = 1'b1;
        send_frame(4, 5, 6'h15, 1'b1);
        err_clear = 1'b0;
        check("clr_vs_set", error_sticky, 1);
        err_clear = 1'b1;
        tick();
        err_clear = 1'b0;
        check("clr_alone", error_sticky, 0);

        // Rising edge of de coincides with the strobe.
        for (int p = 0; p < 5; p++) begin
            de     = 1'b1;
            rrggbb = 6'h33;
            tick();
        end
        de = 1'b0;
        tick();
        tick();
        de         = 1'b1;
        next_frame = 1'b1;
        tick();
        de         = 1'b0;
        next_frame = 1'b0;
        check("edge_pix", pixel_count, 6);
        check("edge_lines", line_count, 2);
        check("edge_sig", signature, crc_c);

        de     = 1'b1;
        rrggbb = 6'h2A;
        tick();
        tick();
        reset_n = 1'b0;
        tick();
        de = 1'b0;
        check("mid_valid", signature_valid, 0);
        check("mid_sig", signature, 16'hFFFF);
        reset_n = 1'b1;
        tick();
        de = 1'b1;
        tick();
        tick();
        de = 1'b0;
        strobe();
        check("mid_sync", signature_valid, 0);
        send_frame(4, 5, 6'h2A, 1'b0);
        check("mid_valid2", signature_valid, 1);
        check("mid_sig2", signature, crc_a);
        check("mid_ferr2", frame_error, 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
